// File: rtl/irq_controller.sv
// Prioritised, maskable, edge-triggered interrupt controller with a REQ/SERV handshake.
// Optional IRQ_ROUND_ROBIN_EN rotates priority starting after the last acknowledged channel.
module irq_controller #(
  parameter int unsigned    N_IRQ      = 4,
  parameter int unsigned    W          = 16,
  parameter logic [W-1:0]   VEC_BASE   = 16'h0020,
  parameter int unsigned    VEC_STRIDE = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_IRQ-1:0]                      irq_in,
  input  logic                                  mask_we,
  input  logic [N_IRQ-1:0]                      mask_wdata,
  output logic [N_IRQ-1:0]                      mask_q,
  output logic [N_IRQ-1:0]                      pending_q,
  output logic                                  int_req,
  output logic [W-1:0]                          int_vec,
  input  logic                                  int_ack,
  input  logic                                  eoi,
  output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] active_id,
  output logic                                  busy
);

  localparam int unsigned IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

  state_e           r_state, w_state_d;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pend, w_pend_d;
  logic [N_IRQ-1:0] r_mask, w_mask_d;
  logic [IDW-1:0]   r_sel, w_sel_d;
  logic [W-1:0]     r_vec, w_vec_d;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_elig;
  logic [IDW-1:0]   w_sel;
  logic             w_found;
  logic [W-1:0]     w_vec;

  assign w_rise = irq_in & ~r_prev;
  assign w_elig = r_pend & r_mask;
  assign w_vec  = VEC_BASE + W'(w_sel) * W'(VEC_STRIDE);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDW-1:0] r_last, w_last_d;
  int unsigned    w_idx;

  // Search begins one past the last acknowledged channel, wrapping modulo N_IRQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      w_idx = 32'(r_last) + 1 + k;
      if (w_idx >= N_IRQ) w_idx = w_idx - N_IRQ;
      if (!w_found && w_elig[IDW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = IDW'(w_idx);
      end
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (!w_found && w_elig[IDW'(i)]) begin
        w_found = 1'b1;
        w_sel   = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_pend_d  = r_pend;
    w_mask_d  = r_mask;
    w_sel_d   = r_sel;
    w_vec_d   = r_vec;
`ifdef IRQ_ROUND_ROBIN_EN
    w_last_d  = r_last;
`endif
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StReq;
          w_sel_d   = w_sel;
          w_vec_d   = w_vec;
        end
      end
      StReq: begin
        if (int_ack) begin
          w_pend_d[r_sel] = 1'b0;
          w_state_d       = StServ;
`ifdef IRQ_ROUND_ROBIN_EN
          w_last_d        = r_sel;
`endif
        end else if (!r_mask[r_sel]) begin
          w_state_d = StIdle;
        end
      end
      StServ: begin
        if (eoi) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // A fresh edge overrides the acknowledge clear in the same cycle.
    w_pend_d = w_pend_d | w_rise;
    if (mask_we) w_mask_d = mask_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_prev  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_sel   <= '0;
      r_vec   <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      r_last  <= IDW'(N_IRQ - 1);
`endif
    end else begin
      r_state <= w_state_d;
      r_prev  <= irq_in;
      r_pend  <= w_pend_d;
      r_mask  <= w_mask_d;
      r_sel   <= w_sel_d;
      r_vec   <= w_vec_d;
`ifdef IRQ_ROUND_ROBIN_EN
      r_last  <= w_last_d;
`endif
    end
  end

  assign mask_q    = r_mask;
  assign pending_q = r_pend;
  assign int_req   = (r_state == StReq);
  assign busy      = (r_state != StIdle);
  assign int_vec   = r_vec;
  assign active_id = r_sel;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic against a
// transaction-level reference model (honours IRQ_ROUND_ROBIN_EN when defined).
module tb_irq_controller;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  pending_q;
  logic          int_req;
  logic [15:0]   int_vec;
  logic          int_ack;
  logic          eoi;
  logic [1:0]    active_id;
  logic          busy;

  always #5 clk = ~clk;

  irq_controller #(
    .N_IRQ     (N),
    .W         (16),
    .VEC_BASE  (16'h0020),
    .VEC_STRIDE(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .mask_q    (mask_q),
    .pending_q (pending_q),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .active_id (active_id),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 requesting, 2 in service.
  logic [N-1:0] m_prev, m_pend, m_mask;
  int           m_ph, m_sel, m_last;
  logic [15:0]  m_vec;

  function automatic int pick(input logic [N-1:0] elig, input int start);
    logic [1:0] j;
    for (int k = 0; k < N; k++) begin
      j = 2'((start + k) % N);
      if (elig[j]) return int'(j);
    end
    return 0;
  endfunction

  task automatic model_step(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                            input logic ack, input logic eo, input logic r);
    logic [N-1:0] elig, nxt;
    logic [1:0]   s;
    int           start;
    if (r) begin
      m_prev = '0; m_pend = '0; m_mask = '0;
      m_ph = 0; m_sel = 0; m_vec = '0; m_last = N - 1;
      return;
    end
    elig = m_pend & m_mask;
    nxt  = m_pend;
    s    = 2'(m_sel);
`ifdef IRQ_ROUND_ROBIN_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    if (m_ph == 0) begin
      if (elig != '0) begin
        m_sel = pick(elig, start);
        m_vec = 16'(32'h20 + m_sel * 2);
        m_ph  = 1;
      end
    end else if (m_ph == 1) begin
      if (ack) begin
        nxt[s] = 1'b0;
        m_last = m_sel;
        m_ph   = 2;
      end else if (!m_mask[s]) begin
        m_ph = 0;
      end
    end else if (eo) begin
      m_ph = 0;
    end
    m_pend = nxt | (irq & ~m_prev);
    m_prev = irq;
    if (mwe) m_mask = mwd;
  endtask

  task automatic compare_all();
    check("int_req",   32'(int_req),   32'(m_ph == 1));
    check("busy",      32'(busy),      32'(m_ph != 0));
    check("active_id", 32'(active_id), 32'(m_sel));
    check("int_vec",   32'(int_vec),   32'(m_vec));
    check("pending_q", 32'(pending_q), 32'(m_pend));
    check("mask_q",    32'(mask_q),    32'(m_mask));
  endtask

  // One clock: drive at negedge, advance model, compare at the next negedge.
  task automatic cyc(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                     input logic ack, input logic eo, input logic r);
    irq_in = irq; mask_we = mwe; mask_wdata = mwd; int_ack = ack; eoi = eo; rst = r;
    model_step(irq, mwe, mwd, ack, eo, r);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_and_unmask();
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] cur;
    int           nreq;
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst_outputs", {busy, int_req, active_id, int_vec, pending_q, mask_q}, 32'h0);

    // Single event on channel 2
    cyc(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("single_no_req_yet", 32'(int_req), 32'h0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("single_req", 32'(int_req), 32'h1);
    check("single_vec", 32'(int_vec), 32'h0024);
    check("single_id",  32'(active_id), 32'h2);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("single_ack_pend", 32'(pending_q), 32'h0);
    check("single_ack_busy", 32'(busy), 32'h1);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("single_eoi", 32'({busy, int_req}), 32'h0);

    // Priority: 3 and 1 together, 1 first
    reset_and_unmask();
    cyc(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("prio_first_id",  32'(active_id), 32'h1);
    check("prio_first_vec", 32'(int_vec), 32'h0022);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("prio_second_id",  32'(active_id), 32'h3);
    check("prio_second_vec", 32'(int_vec), 32'h0026);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

`ifdef IRQ_ROUND_ROBIN_EN
    // Rotation: after serving 1, channels 1 and 2 pending -> 2 wins
    reset_and_unmask();
    cyc(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0110, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rr_id", 32'(active_id), 32'h2);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
`endif

    // Masking: channel 0 latched while masked, serviced after unmask
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mask_pend",   32'(pending_q), 32'h1);
    check("mask_no_req", 32'(int_req), 32'h0);
    cyc(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("mask_wr_edge_req", 32'(int_req), 32'h0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("unmask_req", 32'(int_req), 32'h1);
    check("unmask_id",  32'(active_id), 32'h0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Held level on channel 1: exactly one service
    reset_and_unmask();
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0010, 1'b0, 4'b0000, 1'(i == 2), 1'(i == 3), 1'b0);
      if (int_req) nreq++;
    end
    check("held_nreq", 32'(nreq), 32'h1);
    check("held_pend", 32'(pending_q[1]), 32'h0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Re-trigger race on channel 2
    reset_and_unmask();
    cyc(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("race_pend", 32'(pending_q[2]), 32'h1);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("race_second_req", 32'({int_req, active_id}), 32'h6);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Reset while in service with channel 3 re-pending
    reset_and_unmask();
    cyc(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("midserv_state", 32'({busy, pending_q}), 32'h18);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("midserv_rst", {busy, int_req, active_id, int_vec, pending_q, mask_q}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("midserv_no_req", 32'(int_req), 32'h0);

    // Randomized traffic
    reset_and_unmask();
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      cur = cur ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      cyc(cur, 1'($urandom_range(0, 19) == 0), 4'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
